// File: rtl/panda_pkg.sv
// Shared constants and types for the panda hazard unit: register address width,
// register count and the forward-select encoding.
package panda_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

endpackage

// File: rtl/panda_scoreboard.sv
// One pending bit per architectural register for outstanding long-latency writes.
// A set and a clear of the same register in one cycle leaves the bit set; x0 never sets.
module panda_scoreboard
    import panda_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                set_i,
    input  reg_addr_t           set_addr_i,
    input  logic                clr_i,
    input  reg_addr_t           clr_addr_i,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] pending_q;

    // The clear is applied first so that a set in the same cycle overrides it.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/panda_hazard_unit.sv
// EX-stage operand forwarding plus long-latency scoreboard and decode stall.
// Optional stall counter enabled by defining PANDA_HAZARD_PERF_EN.
module panda_hazard_unit
    import panda_pkg::*;
#(
    parameter int NUM_RS    = 2,
    parameter int NUM_FWD   = 2,
    parameter int FWD_SEL_W = $clog2(NUM_FWD + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_RS*REG_ADDR_W-1:0]    ex_rs_addr_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0]   fwd_rd_addr_i,
    input  logic [NUM_FWD-1:0]              fwd_rd_we_i,
    output logic [NUM_RS*FWD_SEL_W-1:0]     forward_o,
    input  logic [NUM_RS*REG_ADDR_W-1:0]    id_rs_addr_i,
    input  logic [NUM_RS-1:0]               id_rs_used_i,
    input  logic [REG_ADDR_W-1:0]           id_rd_addr_i,
    input  logic                            id_rd_we_i,
    input  logic                            issue_i,
    input  logic                            issue_long_i,
    input  logic                            lwb_valid_i,
    input  logic [REG_ADDR_W-1:0]           lwb_rd_addr_i,
    output logic                            stall_o,
    output logic [NUM_REGS-1:0]             pending_o
`ifdef PANDA_HAZARD_PERF_EN
    ,
    input  logic                            stall_cnt_clr_i,
    output logic [31:0]                     stall_cnt_o
`endif
);

    logic [NUM_REGS-1:0] pending;
    logic                sb_set;
    reg_addr_t           ex_rs;
    reg_addr_t           id_rs;
    logic                raw_hazard;
    logic                waw_hazard;

    // Scanning from oldest to youngest lets the youngest matching stage win.
    always_comb begin
        forward_o = '0;
        ex_rs     = '0;
        for (int p = 0; p < NUM_RS; p++) begin
            ex_rs = ex_rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W];
            forward_o[p*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_W'(FWD_RF);
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_rd_we_i[k] && (ex_rs != '0) &&
                    (fwd_rd_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == ex_rs)) begin
                    forward_o[p*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_W'(k + FWD_STAGE_BASE);
                end
            end
        end
    end

    always_comb begin
        raw_hazard = 1'b0;
        id_rs      = '0;
        for (int p = 0; p < NUM_RS; p++) begin
            id_rs = id_rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W];
            if (id_rs_used_i[p] && (id_rs != '0) && pending[id_rs]) begin
                raw_hazard = 1'b1;
            end
        end
        waw_hazard = id_rd_we_i && (id_rd_addr_i != '0) && pending[id_rd_addr_i];
        stall_o    = raw_hazard | waw_hazard;
    end

    // A stalled instruction is not really issuing, so it must not claim its rd.
    assign sb_set = issue_i & ~stall_o & issue_long_i & id_rd_we_i & (id_rd_addr_i != '0);

    panda_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .set_i      (sb_set),
        .set_addr_i (id_rd_addr_i),
        .clr_i      (lwb_valid_i),
        .clr_addr_i (lwb_rd_addr_i),
        .pending_o  (pending)
    );

    assign pending_o = pending;

`ifdef PANDA_HAZARD_PERF_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr_i) begin
            stall_cnt_d = '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_panda_hazard_unit.sv
// Directed-vector scoreboard bench for panda_hazard_unit: the driver queues
// hand-computed expectations, a monitor pops and compares them at each negedge.
module tb_panda_hazard_unit;
    import panda_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [9:0]  ex_rs_addr_i;
    logic [9:0]  fwd_rd_addr_i;
    logic [1:0]  fwd_rd_we_i;
    logic [3:0]  forward_o;
    logic [9:0]  id_rs_addr_i;
    logic [1:0]  id_rs_used_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    logic        issue_i;
    logic        issue_long_i;
    logic        lwb_valid_i;
    logic [4:0]  lwb_rd_addr_i;
    logic        stall_o;
    logic [31:0] pending_o;
`ifdef PANDA_HAZARD_PERF_EN
    logic        stall_cnt_clr_i = 1'b0;
    logic [31:0] stall_cnt_o;
`endif

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        stall;
        logic [31:0] pend;
        logic        chk_cnt;
        logic [31:0] cnt;
    } expect_t;

    expect_t exp_q[$];
    int      n_vectors     = 0;
    int      n_miscompares = 0;

    always #5 clk_i = ~clk_i;

    panda_hazard_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ex_rs_addr_i  (ex_rs_addr_i),
        .fwd_rd_addr_i (fwd_rd_addr_i),
        .fwd_rd_we_i   (fwd_rd_we_i),
        .forward_o     (forward_o),
        .id_rs_addr_i  (id_rs_addr_i),
        .id_rs_used_i  (id_rs_used_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_rd_we_i    (id_rd_we_i),
        .issue_i       (issue_i),
        .issue_long_i  (issue_long_i),
        .lwb_valid_i   (lwb_valid_i),
        .lwb_rd_addr_i (lwb_rd_addr_i),
        .stall_o       (stall_o),
        .pending_o     (pending_o)
`ifdef PANDA_HAZARD_PERF_EN
        ,
        .stall_cnt_clr_i (stall_cnt_clr_i),
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    // Drive one cycle of inputs just after the rising edge and queue what the DUT must show.
    task automatic apply_stimulus(
        input string       name,
        input logic        rst,
        input logic [9:0]  ex_rs,
        input logic [9:0]  fwd_addr,
        input logic [1:0]  fwd_we,
        input logic [9:0]  id_rs,
        input logic [1:0]  used,
        input logic [4:0]  id_rd,
        input logic        rd_we,
        input logic        issue,
        input logic        is_long,
        input logic        lwb_v,
        input logic [4:0]  lwb_rd,
        input logic [3:0]  exp_fwd,
        input logic        exp_stall,
        input logic [31:0] exp_pend,
        input logic        chk_cnt,
        input logic [31:0] exp_cnt
    );
        expect_t e;
        @(posedge clk_i);
        #1;
        rst_ni        = rst;
        ex_rs_addr_i  = ex_rs;
        fwd_rd_addr_i = fwd_addr;
        fwd_rd_we_i   = fwd_we;
        id_rs_addr_i  = id_rs;
        id_rs_used_i  = used;
        id_rd_addr_i  = id_rd;
        id_rd_we_i    = rd_we;
        issue_i       = issue;
        issue_long_i  = is_long;
        lwb_valid_i   = lwb_v;
        lwb_rd_addr_i = lwb_rd;
        e.name    = name;
        e.fwd     = exp_fwd;
        e.stall   = exp_stall;
        e.pend    = exp_pend;
        e.chk_cnt = chk_cnt;
        e.cnt     = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input expect_t e);
        n_vectors++;
        if (forward_o !== e.fwd) begin
            n_miscompares++;
            $display("[TB] FAIL %s forward_o: got %b expected %b", e.name, forward_o, e.fwd);
        end
        if (stall_o !== e.stall) begin
            n_miscompares++;
            $display("[TB] FAIL %s stall_o: got %b expected %b", e.name, stall_o, e.stall);
        end
        if (pending_o !== e.pend) begin
            n_miscompares++;
            $display("[TB] FAIL %s pending_o: got %h expected %h", e.name, pending_o, e.pend);
        end
`ifdef PANDA_HAZARD_PERF_EN
        if (e.chk_cnt && (stall_cnt_o !== e.cnt)) begin
            n_miscompares++;
            $display("[TB] FAIL %s stall_cnt_o: got %0d expected %0d", e.name, stall_cnt_o, e.cnt);
        end
`endif
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : driver
        int drain;
        rst_ni        = 1'b0;
        ex_rs_addr_i  = '0;
        fwd_rd_addr_i = '0;
        fwd_rd_we_i   = '0;
        id_rs_addr_i  = '0;
        id_rs_used_i  = '0;
        id_rd_addr_i  = '0;
        id_rd_we_i    = 1'b0;
        issue_i       = 1'b0;
        issue_long_i  = 1'b0;
        lwb_valid_i   = 1'b0;
        lwb_rd_addr_i = '0;

        //              name            rst ex_rs         fwd_addr      we     id_rs          used   rd     we   iss  lng  lwb  lrd    fwd      st   pend          cc   cnt
        apply_stimulus("reset",         0, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        1,   32'd0);
        apply_stimulus("fwd_both",      1, {5'd0,5'd5},  {5'd5,5'd5},  2'b11, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0001, 0,   32'h0,        0,   32'd0);
        apply_stimulus("fwd_old",       1, {5'd5,5'd5},  {5'd5,5'd5},  2'b10, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b1010, 0,   32'h0,        0,   32'd0);
        apply_stimulus("fwd_x0",        1, {5'd3,5'd0},  {5'd3,5'd0},  2'b11, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b1000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("lu_issue",      1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd7,  1,   1,   1,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("lu_stall",  1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd7},   2'b01, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 1,   32'h80,       0,   32'd0);
        end
        apply_stimulus("lu_wb",         1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd7},   2'b01, 5'd0,  0,   0,   0,   1,   5'd7,  4'b0000, 1,   32'h80,       0,   32'd0);
        apply_stimulus("lu_release",    1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd7},   2'b01, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("waw_issue",     1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd9,  1,   1,   1,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("waw_stall",     1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd9,  1,   1,   1,   0,   5'd0,  4'b0000, 1,   32'h200,      0,   32'd0);
        apply_stimulus("waw_wb",        1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd9,  1,   1,   1,   1,   5'd9,  4'b0000, 1,   32'h200,      0,   32'd0);
        apply_stimulus("waw_release",   1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd9,  1,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("setclr_same",   1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd3,  1,   1,   1,   1,   5'd3,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("setclr_held",   1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h8,        0,   32'd0);
        apply_stimulus("x3_wb",         1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   1,   5'd3,  4'b0000, 0,   32'h8,        0,   32'd0);
        apply_stimulus("x3_clear",      1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("x0_issue",      1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  1,   1,   1,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("x0_none",       1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("x12_issue",     1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd12, 1,   1,   1,   0,   5'd0,  4'b0000, 0,   32'h0,        0,   32'd0);
        apply_stimulus("unused_port",   1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd12,5'd12}, 2'b00, 5'd4,  1,   1,   1,   0,   5'd0,  4'b0000, 0,   32'h1000,     0,   32'd0);
        apply_stimulus("raw_port1",     1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd12,5'd12}, 2'b10, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 1,   32'h1010,     1,   32'd6);
        apply_stimulus("async_reset",   0, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd12,5'd12}, 2'b10, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        1,   32'd0);
        apply_stimulus("after_reset",   1, {5'd0,5'd0},  {5'd0,5'd0},  2'b00, {5'd0,5'd0},   2'b00, 5'd0,  0,   0,   0,   0,   5'd0,  4'b0000, 0,   32'h0,        1,   32'd0);

        drain = 0;
        while ((exp_q.size() > 0) && (drain < 10)) begin
            @(posedge clk_i);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/panda_hazard_unit.md
# panda_hazard_unit

Parametrised successor to the EX-stage forward unit. It selects operand forwarding sources for each EX-stage read port across a configurable number of forwarding stages. It also owns a register scoreboard for long-latency results (load, mul, div). From that scoreboard it raises a decode stall for RAW and WAW hazards that forwarding cannot resolve. It sits between ID and EX, driven by the pipeline registers and the long-latency writeback port.

## Interface
- NUM_RS, 2: source-operand read ports per instruction
- NUM_FWD, 2: forwarding stages, index 0 youngest (EX/MEM), NUM_FWD-1 oldest (MEM/WB)
- FWD_SEL_W, $clog2(NUM_FWD+1): width of each forward select

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- ex_rs_addr_i  in  NUM_RS×5  source addresses of the instruction in EX
- fwd_rd_addr_i  in  NUM_FWD×5  destination address held in each forwarding stage
- fwd_rd_we_i  in  NUM_FWD  stage will write rd with data valid in that stage
- forward_o  out  NUM_RS×FWD_SEL_W  0 = register file, k = forwarding stage k-1
- id_rs_addr_i  in  NUM_RS×5  source addresses of the instruction in ID
- id_rs_used_i  in  NUM_RS  port actually read by the ID instruction
- id_rd_addr_i  in  5  ID destination address
- id_rd_we_i  in  1  ID instruction writes rd
- issue_i  in  1  ID instruction advances to EX this cycle (qualified internally with ~stall_o)
- issue_long_i  in  1  the issuing instruction is long-latency
- lwb_valid_i  in  1  long-latency result written to register file this cycle
- lwb_rd_addr_i  in  5  its destination
- stall_o  out  1  hold ID, insert bubble in EX
- pending_o  out  32  scoreboard bits, bit 0 always 0

## Operation
- **Forwarding (per port p):**
  - Select the lowest index k where fwd_rd_we_i[k] is set, fwd_rd_addr_i[k] equals ex_rs_addr_i[p], and the address is nonzero.
  - forward_o[p] = k+1. If no stage matches, forward_o[p] = 0.
  - Priority goes strictly to the youngest matching stage.
- **Scoreboard:** 32 bits, one per architectural register.
  - Set: issue_i & ~stall_o & issue_long_i & id_rd_we_i & (id_rd_addr_i ≠ 0) sets bit id_rd_addr_i.
  - Clear: lwb_valid_i clears bit lwb_rd_addr_i.
  - Set and clear of the same register in the same cycle: the set wins.
  - Writes to x0 are ignored. Bit 0 is never set.
- **Stall:** stall_o = RAW | WAW.
  - RAW: for any port p, id_rs_used_i[p] & pending[id_rs_addr_i[p]], with a nonzero address.
  - WAW: id_rd_we_i & pending[id_rd_addr_i], with a nonzero address.
  - Stall evaluates the registered scoreboard. A writeback in cycle t releases the stall in cycle t+1; there is no same-cycle bypass.
  - Consequence of WAW: at most one outstanding long write per register, so a 1-bit scoreboard is sufficient.
- **lwb_valid_i to a non-pending register:** no effect, no error. Verification flags it as a protocol violation.
- **Reset mid-operation:** all pending bits clear immediately (asynchronous). Writebacks still in flight then land on cleared bits harmlessly.

## Timing
- forward_o and stall_o are combinational from inputs and registered state, with zero latency.
- Scoreboard updates on the rising edge of clk_i.
  - Long issue in cycle t sets the bit visible in t+1.
  - A dependent instruction in ID at t+1 stalls.
- Minimum stall for a dependent instruction = writeback cycle − issue cycle.
- Reset values: pending_o = 0, stall_o = 0 (given id_rs_used_i = 0 and id_rd_we_i = 0), perf counter = 0.
- forward_o depends only on inputs and has no reset state.

## Configuration
- **Macro:** PANDA_HAZARD_PERF_EN.
- **Defined:**
  - Adds output stall_cnt_o, 32 bits, which increments each cycle stall_o is high.
  - It saturates at 0xFFFF_FFFF and resets to 0.
  - Adds input stall_cnt_clr_i (1 bit), which synchronously zeroes the counter. Clear has priority over increment.
- **Undefined:** the counter and both ports are absent. All other behaviour is identical.

## Structure
- Shared in panda_pkg:
  - REG_ADDR_W = 5, NUM_REGS = 32
  - typedef reg_addr_t
  - the forward-select encoding constants FWD_RF = 0 and FWD_STAGE_BASE = 1
- One sub-module: panda_scoreboard. It holds the 32-bit register with its set/clear ports, set-over-clear priority and x0 masking, and exposes pending bits.
- Forwarding select and stall logic stay in the top level.

## Test plan
- **Priority:** ex_rs_addr_i[0]=5; stage 0 and stage 1 both write x5 → forward_o[0]=1. Drop stage 0's we → forward_o[0]=2. Set the address to x0 → 0.
- **Load-use:** long issue rd=7 at t, then ID reads x7 at t+1 → stall_o=1 until lwb_valid_i(x7) at t+4; stall_o=0 at t+5; pending_o[7] clears at t+5.
- **WAW:** x9 pending; ID writes x9 with id_rs_used_i=0 → stall_o=1. After x9 writeback → stall clears next cycle.
- **Simultaneous set/clear:** lwb_valid_i x3 and a long issue rd=x3 in the same cycle → pending_o[3] stays 1.
- **x0 and unused ports:** long issue rd=0 → pending_o=0. id_rs_used_i=0 with an address of a pending register → no stall.
- **Reset:** with x4 and x12 pending, assert rst_ni low mid-cycle → pending_o=0 and stall_o=0 immediately. With PANDA_HAZARD_PERF_EN defined, stall_cnt_o also reads 0 after reset.
